// File: rtl/counter_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_scheduler_if
// Description : Bundle of requester-side and datapath-side signals of the
//               round-robin counter scheduler. The master modport is the
//               scheduler; the slave modport is the surrounding environment
//               (client FSMs plus the shared counter datapath).
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_scheduler_if #(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int LEN_WIDTH = 8
);
    // Requester side, flattened: requester i owns slice i of each bus
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_start;
    logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [BUS_WIDTH-1:0]         result;
    logic                         busy;

    // Shared counter datapath side
    logic                         cnt_load;
    logic [BUS_WIDTH-1:0]         cnt_load_val;
    logic                         cnt_en;
    logic [BUS_WIDTH-1:0]         cnt_val;

    modport master (
        input  req, req_start, req_len, cnt_val,
        output grant, done, result, busy, cnt_load, cnt_load_val, cnt_en
    );

    modport slave (
        output req, req_start, req_len, cnt_val,
        input  grant, done, result, busy, cnt_load, cnt_load_val, cnt_en
    );
endinterface
`default_nettype wire

// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : counter_scheduler
// Description : Round-robin scheduler sharing one loadable up-counter between
//               NUM_REQ requesters. The winner's start value is loaded, the
//               counter is enabled for exactly len cycles, and the final
//               count is returned with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int LEN_WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    counter_scheduler_if.master bus
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_SUM_W = c_IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [c_IDX_W-1:0]     r_sel;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_done;
    logic [BUS_WIDTH-1:0]   r_result;
    logic                   r_busy;
    logic                   r_cnt_load;
    logic [BUS_WIDTH-1:0]   r_load_val;
    logic                   r_cnt_en;

    // Per-requester views of the flattened buses, and the requester index
    // examined at each scan offset from the round-robin pointer.
    logic [BUS_WIDTH-1:0]   w_start [NUM_REQ];
    logic [LEN_WIDTH-1:0]   w_len   [NUM_REQ];
    logic [c_IDX_W-1:0]     w_cand  [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        logic [c_SUM_W-1:0] w_sum;

        assign w_start[k] = bus.req_start[k*BUS_WIDTH +: BUS_WIDTH];
        assign w_len[k]   = bus.req_len[k*LEN_WIDTH +: LEN_WIDTH];
        assign w_sum      = {1'b0, r_ptr} + c_SUM_W'(k);
        assign w_cand[k]  = (w_sum >= c_SUM_W'(NUM_REQ))
                          ? c_IDX_W'(w_sum - c_SUM_W'(NUM_REQ))
                          : c_IDX_W'(w_sum);
    end

    logic                   w_found;
    logic [c_IDX_W-1:0]     w_pick;
    logic [c_IDX_W-1:0]     w_ptr_next;

    // Pick the first active requester at or after the pointer; scanning the
    // offsets downward lets the smallest offset win.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[w_cand[k]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[k];
            end
        end
    end

    // Pointer advances to the requester just after the one being served.
    assign w_ptr_next = (r_sel == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + c_IDX_W'(1);

    // Scheduler FSM; every output is produced as a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_remaining <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_cnt_load  <= 1'b0;
            r_load_val  <= '0;
            r_cnt_en    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel       <= w_pick;
                        r_load_val  <= w_start[w_pick];
                        r_remaining <= w_len[w_pick];
                        r_grant     <= NUM_REQ'(1) << w_pick;
                        r_cnt_load  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_cnt_load <= 1'b0;
                    if (r_remaining == '0) begin
                        // Nothing to count: the loaded start is the answer.
                        r_done   <= r_grant;
                        r_result <= r_load_val;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt_en <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_remaining <= r_remaining - LEN_WIDTH'(1);
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        // The final increment lands on this same edge, so the
                        // registered result takes cnt_val + 1, which is the
                        // value the datapath shows throughout DONE.
                        r_cnt_en <= 1'b0;
                        r_done   <= r_grant;
                        r_result <= bus.cnt_val + BUS_WIDTH'(1);
                        r_state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.busy         = r_busy;
    assign bus.cnt_load     = r_cnt_load;
    assign bus.cnt_load_val = r_load_val;
    assign bus.cnt_en       = r_cnt_en;

endmodule
`default_nettype wire
